// File: rtl/ray_marcher.sv
// Fixed-point sphere-tracing engine: marches one ray against a sphere or an
// axis-aligned cube centred at the origin and reports hit/miss, the marched
// distance t and the final point ro + t*rd. All values are signed Q8.24.

package vec_pkg;
  typedef logic signed [31:0] fp;
  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;
endpackage

module ray_marcher
  import vec_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 64,
  parameter fp           MAX_DIST  = 32'h1000_0000,
  parameter fp           EPSILON   = 32'h0000_4189,
  parameter fp           SPHERE_R  = 32'h0080_0000,
  parameter fp           BOX_B     = 32'h0080_0000
) (
  input  logic clk,
  input  logic rst,
  input  vec3  rayOrigin,
  input  vec3  rayDir,
  input  logic valid_in,
  input  logic obj_sel,
  output fp    distance,
  output vec3  point,
  output logic valid_out,
  output logic hit
);

  localparam int SW = $clog2(MAX_STEPS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POS, S_SDF, S_SQRT, S_DIST, S_CHECK, S_FIN, S_DONE
  } state_t;

  // Q8.24 multiply: full 64-bit signed product, keep bits [55:24]
  function automatic fp fx_mul(fp a, fp b);
    return fp'((64'(a) * 64'(b)) >>> 24);
  endfunction

  // Q8.24 square widened to Q16.48
  function automatic logic [63:0] fx_sq(fp a);
    return 64'(a) * 64'(a);
  endfunction

  function automatic fp fx_abs(fp a);
    return a[31] ? -a : a;
  endfunction

  function automatic fp fx_max0(fp a);
    return a[31] ? '0 : a;
  endfunction

  function automatic fp fx_max(fp a, fp b);
    return (a > b) ? a : b;
  endfunction

  state_t          r_state;
  vec3             r_ro;
  vec3             r_rd;
  logic            r_sel;
  fp               r_t;
  logic [SW-1:0]   r_steps;
  vec3             r_p;
  fp               r_inner;
  fp               r_d;
  logic [63:0]     r_rad;
  logic [33:0]     r_rem;
  logic [31:0]     r_root;
  logic [4:0]      r_cnt;

  // Current sample point for the latched ray at the current t
  vec3 w_p;
  assign w_p.x = r_ro.x + fx_mul(r_t, r_rd.x);
  assign w_p.y = r_ro.y + fx_mul(r_t, r_rd.y);
  assign w_p.z = r_ro.z + fx_mul(r_t, r_rd.z);

  // Cube: q = |p| - b per axis; sphere just uses p directly
  fp w_qx, w_qy, w_qz, w_sx, w_sy, w_sz, w_qmax, w_inner;
  assign w_qx    = fx_abs(r_p.x) - BOX_B;
  assign w_qy    = fx_abs(r_p.y) - BOX_B;
  assign w_qz    = fx_abs(r_p.z) - BOX_B;
  assign w_sx    = r_sel ? fx_max0(w_qx) : r_p.x;
  assign w_sy    = r_sel ? fx_max0(w_qy) : r_p.y;
  assign w_sz    = r_sel ? fx_max0(w_qz) : r_p.z;
  assign w_qmax  = fx_max(fx_max(w_qx, w_qy), w_qz);
  assign w_inner = w_qmax[31] ? w_qmax : '0;

  logic [63:0] w_sq;
  assign w_sq = fx_sq(w_sx) + fx_sq(w_sy) + fx_sq(w_sz);

  // One restoring square-root step: bring down two radicand bits, try 4q+1
  logic [35:0] w_rem_sh, w_trial;
  logic        w_ge;
  assign w_rem_sh = {r_rem, r_rad[63:62]};
  assign w_trial  = {2'b00, r_root, 2'b01};
  assign w_ge     = (w_rem_sh >= w_trial);

  // Root of a Q16.48 square is already Q8.24
  fp w_len, w_d;
  assign w_len = $signed(r_root);
  assign w_d   = r_sel ? (w_len + r_inner) : (w_len - SPHERE_R);

  // Termination tests for the CHECK state
  fp             w_t_new;
  logic [SW-1:0] w_steps_nx;
  logic          w_hit, w_stop;
  assign w_t_new    = r_t + r_d;
  assign w_steps_nx = r_steps + SW'(1);
  assign w_hit      = (r_d < EPSILON);
  assign w_stop     = (w_t_new > MAX_DIST) || (w_steps_nx == SW'(MAX_STEPS));

  // March FSM with datapath registers and registered outputs
  // NOTE: every register here is assigned with <= so all reads see the
  // pre-edge values, which is what makes the state/datapath handoff exact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ro      <= '0;
      r_rd      <= '0;
      r_sel     <= 1'b0;
      r_t       <= '0;
      r_steps   <= '0;
      r_p       <= '0;
      r_inner   <= '0;
      r_d       <= '0;
      r_rad     <= '0;
      r_rem     <= '0;
      r_root    <= '0;
      r_cnt     <= '0;
      distance  <= '0;
      point     <= '0;
      valid_out <= 1'b0;
      hit       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_ro    <= rayOrigin;
            r_rd    <= rayDir;
            r_sel   <= obj_sel;
            r_t     <= '0;
            r_steps <= '0;
            r_state <= S_POS;
          end
        end
        S_POS: begin
          r_p     <= w_p;
          r_state <= S_SDF;
        end
        S_SDF: begin
          r_rad   <= w_sq;
          r_inner <= w_inner;
          r_rem   <= '0;
          r_root  <= '0;
          r_cnt   <= '0;
          r_state <= S_SQRT;
        end
        S_SQRT: begin
          r_rad <= {r_rad[61:0], 2'b00};
          if (w_ge) begin
            r_rem  <= 34'(w_rem_sh - w_trial);
            r_root <= {r_root[30:0], 1'b1};
          end else begin
            r_rem  <= 34'(w_rem_sh);
            r_root <= {r_root[30:0], 1'b0};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_DIST;
        end
        S_DIST: begin
          r_d     <= w_d;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_hit) begin
            distance  <= r_t;
            point     <= r_p;
            hit       <= 1'b1;
            valid_out <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_t     <= w_t_new;
            r_steps <= w_steps_nx;
            r_state <= w_stop ? S_FIN : S_POS;
          end
        end
        S_FIN: begin
          // Miss: report the point at the overshooting t
          distance  <= r_t;
          point     <= w_p;
          hit       <= 1'b0;
          valid_out <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          valid_out <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_marcher.sv
// Directed self-checking bench for ray_marcher: hand-computed sphere and cube
// rays, a miss, reset abort, busy-time start requests and restart.

module tb_ray_marcher;
  import vec_pkg::*;

  logic clk = 1'b0;
  logic rst;
  vec3  rayOrigin, rayDir;
  logic valid_in, obj_sel;
  fp    distance;
  vec3  point;
  logic valid_out, hit;

  int n_cmp   = 0;
  int n_fail  = 0;
  int pulses  = 0;
  int lat;
  int p_before;

  localparam fp ONE   = 32'h0100_0000;
  localparam fp HALF  = 32'h0080_0000;
  localparam fp FIVE  = 32'h0500_0000;
  localparam fp NONE  = -32'sh0100_0000;
  localparam fp NRT2  = -32'sh00B5_04F3;  // -0.70710678
  localparam int MAX_LAT = 1 + 36 * 64 + 2;

  ray_marcher dut (
    .clk       (clk),
    .rst       (rst),
    .rayOrigin (rayOrigin),
    .rayDir    (rayDir),
    .valid_in  (valid_in),
    .obj_sel   (obj_sel),
    .distance  (distance),
    .point     (point),
    .valid_out (valid_out),
    .hit       (hit)
  );

  always #5 clk = ~clk;

  // Count result pulses (one per cycle valid_out is high)
  always @(posedge clk) if (valid_out === 1'b1) pulses++;

  function automatic vec3 v(fp x, fp y, fp z);
    vec3 r;
    r.x = x;
    r.y = y;
    r.z = z;
    return r;
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input fp obs, input fp exp, input int tol);
    int diff;
    n_cmp++;
    diff = int'(obs) - int'(exp);
    if (diff < 0) diff = -diff;
    assert (diff <= tol) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h +/- %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic start_ray(input vec3 ro, input vec3 rd, input logic sel);
    @(negedge clk);
    rayOrigin = ro;
    rayDir    = rd;
    obj_sel   = sel;
    valid_in  = 1'b1;
    @(negedge clk);
    valid_in  = 1'b0;
  endtask

  // Wait (bounded) for the result pulse; leaves us at the negedge where it is high
  task automatic wait_result(input string tag, output int cycles);
    cycles = 0;
    while (valid_out !== 1'b1 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, " valid_out"}, valid_out, 1'b1);
  endtask

  task automatic check_pulse_end(input string tag);
    @(negedge clk);
    check({tag, " pulse width"}, valid_out, 1'b0);
  endtask

  initial begin
    rst       = 1'b0;
    valid_in  = 1'b0;
    obj_sel   = 1'b0;
    rayOrigin = '0;
    rayDir    = '0;
    #12;
    check("reset distance", distance, 32'h0);
    check("reset point", point, 96'h0);
    check("reset hit", hit, 1'b0);
    check("reset valid_out", valid_out, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Sphere, straight down z: two iterations, hit at t=0.5
    start_ray(v(0, 0, ONE), v(0, 0, NONE), 1'b0);
    wait_result("t1", lat);
    check("t1 hit", hit, 1'b1);
    check("t1 distance", distance, HALF);
    check("t1 point", point, v(0, 0, HALF));
    check("t1 latency lo", (lat >= 72), 1'b1);
    check("t1 latency hi", (lat <= 1 + 36 * 2 + 2), 1'b1);
    check_pulse_end("t1");

    // Sphere, diagonal from (1,1,0): t = sqrt2 - 0.5
    start_ray(v(ONE, ONE, 0), v(NRT2, NRT2, 0), 1'b0);
    wait_result("t2", lat);
    check("t2 hit", hit, 1'b1);
    check_near("t2 distance", distance, 32'h00EA_09E6, 64);
    check_near("t2 point.x", point.x, 32'h005A_827A, 64);
    check_near("t2 point.y", point.y, 32'h005A_827A, 64);
    check("t2 point.z", point.z, 32'h0);
    check_pulse_end("t2");

    // Sphere, from y=5 downward: t = 4.5
    start_ray(v(0, FIVE, 0), v(0, NONE, 0), 1'b0);
    wait_result("t3", lat);
    check("t3 hit", hit, 1'b1);
    check("t3 distance", distance, 32'h0480_0000);
    check("t3 point", point, v(0, HALF, 0));
    check_pulse_end("t3");

    // Sphere, ray passing at distance 1: miss after t exceeds 16
    start_ray(v(0, 0, ONE), v(0, ONE, 0), 1'b0);
    wait_result("t4", lat);
    check("t4 hit", hit, 1'b0);
    check("t4 distance > MAX_DIST", (distance > 32'sh1000_0000), 1'b1);
    check("t4 point.y", point.y, distance);
    check("t4 point.x", point.x, 32'h0);
    check("t4 point.z", point.z, ONE);
    check("t4 latency bound", (lat <= MAX_LAT), 1'b1);
    check_pulse_end("t4");

    // Cube from z=1: hit on the face at t=0.5
    start_ray(v(0, 0, ONE), v(0, 0, NONE), 1'b1);
    wait_result("t5", lat);
    check("t5 hit", hit, 1'b1);
    check("t5 distance", distance, HALF);
    check("t5 point", point, v(0, 0, HALF));
    check_pulse_end("t5");

    // Cube from the origin: inside, hit immediately at t=0
    start_ray(v(0, 0, 0), v(0, 0, NONE), 1'b1);
    wait_result("t6", lat);
    check("t6 hit", hit, 1'b1);
    check("t6 distance", distance, 32'h0);
    check("t6 point", point, v(0, 0, 0));
    check("t6 latency", (lat <= 1 + 36 + 2), 1'b1);
    check_pulse_end("t6");

    // Reset mid-march: ray aborted, outputs cleared, no pulse afterwards
    p_before = pulses;
    start_ray(v(0, FIVE, 0), v(0, NONE, 0), 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort distance", distance, 32'h0);
    check("abort point", point, 96'h0);
    check("abort hit", hit, 1'b0);
    check("abort valid_out", valid_out, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check("abort no pulse", pulses, p_before);
    check("abort distance held", distance, 32'h0);

    // Start request while busy is ignored: only the first ray completes
    p_before = pulses;
    start_ray(v(0, FIVE, 0), v(0, NONE, 0), 1'b0);
    repeat (10) @(negedge clk);
    rayOrigin = v(0, 0, ONE);
    rayDir    = v(0, 0, NONE);
    obj_sel   = 1'b1;
    valid_in  = 1'b1;
    @(negedge clk);
    valid_in  = 1'b0;
    wait_result("busy", lat);
    check("busy hit", hit, 1'b1);
    check("busy distance", distance, 32'h0480_0000);
    check("busy point", point, v(0, HALF, 0));
    check_pulse_end("busy");
    repeat (100) @(negedge clk);
    check("busy single pulse", pulses - p_before, 1);

    // Fresh ray after the pulse
    start_ray(v(0, 0, ONE), v(0, 0, NONE), 1'b0);
    wait_result("fresh", lat);
    check("fresh hit", hit, 1'b1);
    check("fresh distance", distance, HALF);
    check("fresh point", point, v(0, 0, HALF));
    check_pulse_end("fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
